// File: rtl/turbidez_responder_if.sv
// turbidez_responder_if: controller handshake and SPI ADC pins of the turbidity responder
interface turbidez_responder_if;
    logic       enable_esp;
    logic       ready_from_esp;
    logic [3:0] turbidez;
    logic       adc_cs_n;
    logic       adc_sclk;
    logic       adc_miso;
    modport master (output enable_esp, adc_miso, input ready_from_esp, turbidez, adc_cs_n, adc_sclk);
    modport slave (input enable_esp, adc_miso, output ready_from_esp, turbidez, adc_cs_n, adc_sclk);
endinterface

// File: rtl/turbidez_responder.sv
// turbidez_responder: averages 2^N_LOG2 SPI ADC frames per request and returns a 4-bit turbidity level
module turbidez_responder #(
    parameter int CLK_DIV    = 4,
    parameter int N_LOG2     = 2,
    parameter int GAP_CYCLES = 8,
    parameter int READY_LEN  = 1
) (
    input logic           clk,
    input logic           reset,
    turbidez_responder_if.slave bus
);
    localparam int AW = 12 + N_LOG2;
    localparam int MX = CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES;
    localparam int DW = MX > 1 ? $clog2(MX) : 1;
    localparam int RW = READY_LEN > 1 ? $clog2(READY_LEN) : 1;

    typedef enum logic [2:0] {IDLE, GAP, FRAME, ACCUM, DONE, WAIT_LOW} state_t;

    state_t        state_q, state_d;
    logic          en_q;
    logic          cs_n_q, cs_n_d, sclk_q, sclk_d, rdy_q, rdy_d;
    logic [DW-1:0] div_q, div_d;
    logic [5:0]    hc_q, hc_d;
    logic [15:0]   sh_q, sh_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [N_LOG2:0] cnt_q, cnt_d;
    logic [3:0]    turb_q, turb_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          start, tick, unused_frame_bits;

    assign start = bus.enable_esp & ~en_q;
    assign tick = div_q == DW'(CLK_DIV - 1);
    assign unused_frame_bits = ^{sh_q[15:13], sh_q[0]};

    assign bus.adc_cs_n = cs_n_q;
    assign bus.adc_sclk = sclk_q;
    assign bus.turbidez = turb_q;
    assign bus.ready_from_esp = rdy_q;

    // en_q is left out of reset so a request held through reset does not look like a new edge
    always_ff @(posedge clk) begin
        en_q <= bus.enable_esp;
        if (reset) begin
            state_q <= IDLE;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            rdy_q   <= 1'b0;
            div_q   <= '0;
            hc_q    <= '0;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            turb_q  <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            rdy_q   <= rdy_d;
            div_q   <= div_d;
            hc_q    <= hc_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            turb_q  <= turb_d;
            rcnt_q  <= rcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        div_d   = div_q;
        hc_d    = hc_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        turb_d  = turb_q;
        rdy_d   = rdy_q && rcnt_q != '0;
        rcnt_d  = rcnt_q != '0 ? rcnt_q - 1'b1 : '0;
        case (state_q)
            IDLE: if (start) begin
                acc_d   = '0;
                cnt_d   = '0;
                div_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                div_d = div_q + 1'b1;
                if (div_q == DW'(GAP_CYCLES - 1)) begin
                    div_d   = '0;
                    hc_d    = '0;
                    cs_n_d  = 1'b0;
                    state_d = FRAME;
                end
            end
            // hc_q counts sclk half-periods; 32 means the 16th falling edge has just happened
            FRAME: if (hc_q == 6'd32) begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                state_d = ACCUM;
            end else begin
                div_d = tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    sclk_d = ~sclk_q;
                    hc_d   = hc_q + 1'b1;
                end
                if (tick && !sclk_q) sh_d = {sh_q[14:0], bus.adc_miso};
            end
            ACCUM: begin
                acc_d   = acc_q + AW'(sh_q[12:1]);
                cnt_d   = cnt_q + 1'b1;
                div_d   = '0;
                state_d = cnt_d[N_LOG2] ? DONE : GAP;
            end
            DONE: begin
                turb_d  = acc_q[N_LOG2 + 11 -: 4];
                rdy_d   = 1'b1;
                rcnt_d  = RW'(READY_LEN - 1);
                state_d = WAIT_LOW;
            end
            WAIT_LOW: if (!en_q && !rdy_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!bus.enable_esp && (state_q == GAP || state_q == FRAME || state_q == ACCUM)) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
        end
    end
endmodule

// File: tb/tb_turbidez_responder.sv
// tb_turbidez_responder: randomized bench with a frame-level ADC model and an averaging reference
module tb_turbidez_responder;
    localparam int LAT  = 4 * (8 + 1 + 128 + 1) + 2;
    localparam int LAT1 = 1 * (8 + 1 + 128 + 1) + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0, fails = 0;
    int vals[$], fed[$];
    int cs_falls = 0, sclk_rises = 0, rdy_cycles = 0;
    int bi0 = 0, bi1 = 0;
    logic [15:0] fr0, fr1;
    logic [11:0] d1 = 12'hFFF;

    turbidez_responder_if b0 ();
    turbidez_responder_if b1 ();

    turbidez_responder dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    turbidez_responder #(.N_LOG2(0)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    always #20 clk = ~clk;

    // ADC models: junk in bits [15:13] and [0], data in [12:1], next bit driven after each sclk fall
    always @(negedge b0.adc_cs_n) begin
        fed.push_back(vals.size() > 0 ? vals.pop_front() : 0);
        fr0 = {3'($urandom), 12'(fed[$]), 1'($urandom)};
        bi0 = 15;
        b0.adc_miso = fr0[15];
        cs_falls++;
    end
    always @(negedge b0.adc_sclk) if (!b0.adc_cs_n && bi0 > 0) begin
        bi0--;
        b0.adc_miso = fr0[bi0];
    end
    always @(posedge b0.adc_sclk) sclk_rises++;
    always @(negedge b1.adc_cs_n) begin
        fr1 = {3'($urandom), d1, 1'($urandom)};
        bi1 = 15;
        b1.adc_miso = fr1[15];
    end
    always @(negedge b1.adc_sclk) if (!b1.adc_cs_n && bi1 > 0) begin
        bi1--;
        b1.adc_miso = fr1[bi1];
    end
    always @(negedge clk) if (b0.ready_from_esp === 1'b1) rdy_cycles++;

    function automatic int model_turb(input int n_log2);
        int sum = 0;
        foreach (fed[i]) sum += fed[i];
        return (sum / (1 << n_log2)) / 256;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_const(input int v);
        vals.delete();
        repeat (4) vals.push_back(v);
    endtask

    task automatic load_rand;
        vals.delete();
        repeat (4) vals.push_back(int'($urandom_range(0, 4095)));
    endtask

    task automatic request(output int lat);
        fed.delete();
        lat = -1;
        b0.enable_esp = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            step(1);
            if (b0.ready_from_esp === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_req;
        b0.enable_esp = 1'b0;
        step(3);
    endtask

    task automatic test_reset;
        b0.enable_esp = 1'b0;
        b1.enable_esp = 1'b0;
        b0.adc_miso = 1'b0;
        b1.adc_miso = 1'b0;
        reset = 1'b1;
        step(4);
        reset = 1'b0;
        checks++;
        if ({b0.adc_cs_n, b0.adc_sclk, b0.turbidez, b0.ready_from_esp} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_outputs got %b exp %b", {b0.adc_cs_n, b0.adc_sclk, b0.turbidez, b0.ready_from_esp}, 7'b1000000);
        end
        checks++;
        if ({b1.adc_cs_n, b1.adc_sclk, b1.turbidez, b1.ready_from_esp} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_outputs_n0 got %b exp %b", {b1.adc_cs_n, b1.adc_sclk, b1.turbidez, b1.ready_from_esp}, 7'b1000000);
        end
        for (int i = 0; i < 100; i++) begin
            step(1);
            checks++;
            if (b0.adc_cs_n !== 1'b1 || b0.adc_sclk !== 1'b0) begin
                fails++;
                $display("FAIL idle_cs_n cycle %0d got cs_n=%b sclk=%b exp cs_n=1 sclk=0", i, b0.adc_cs_n, b0.adc_sclk);
            end
        end
    endtask

    task automatic test_single;
        int lat, c0, s0, r0, e;
        load_const(12'hC00);
        c0 = cs_falls;
        s0 = sclk_rises;
        r0 = rdy_cycles;
        request(lat);
        e = model_turb(2);
        checks++;
        if (lat !== LAT) begin fails++; $display("FAIL single_latency got %0d exp %0d", lat, LAT); end
        checks++;
        if (b0.turbidez !== 4'(e)) begin fails++; $display("FAIL single_turbidez got %0d exp %0d", b0.turbidez, e); end
        step(3);
        checks++;
        if (rdy_cycles - r0 !== 1) begin fails++; $display("FAIL single_ready_len got %0d exp 1", rdy_cycles - r0); end
        checks++;
        if (cs_falls - c0 !== 4) begin fails++; $display("FAIL single_frames got %0d exp 4", cs_falls - c0); end
        checks++;
        if (sclk_rises - s0 !== 64) begin fails++; $display("FAIL single_sclk got %0d exp 64", sclk_rises - s0); end
        release_req;
    endtask

    task automatic test_average;
        int lat, e;
        vals.delete();
        vals.push_back(12'h900);
        vals.push_back(12'h9FF);
        vals.push_back(12'h900);
        vals.push_back(12'h9FF);
        request(lat);
        e = model_turb(2);
        checks++;
        if (b0.turbidez !== 4'(e)) begin fails++; $display("FAIL avg_turbidez got %0d exp %0d", b0.turbidez, e); end
        release_req;
        d1 = 12'hFFF;
        b1.enable_esp = 1'b1;
        lat = -1;
        for (int n = 1; n <= 1000; n++) begin
            step(1);
            if (b1.ready_from_esp === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat !== LAT1) begin fails++; $display("FAIL n0_latency got %0d exp %0d", lat, LAT1); end
        checks++;
        if (b1.turbidez !== 4'(d1 / 256)) begin fails++; $display("FAIL n0_turbidez got %0d exp %0d", b1.turbidez, d1 / 256); end
        b1.enable_esp = 1'b0;
        step(3);
    endtask

    task automatic test_random;
        int lat, e;
        for (int k = 0; k < 5; k++) begin
            load_rand;
            request(lat);
            e = model_turb(2);
            checks++;
            if (lat !== LAT) begin fails++; $display("FAIL rand_latency %0d got %0d exp %0d", k, lat, LAT); end
            checks++;
            if (b0.turbidez !== 4'(e)) begin fails++; $display("FAIL rand_turbidez %0d got %0d exp %0d", k, b0.turbidez, e); end
            release_req;
        end
    endtask

    task automatic test_held;
        int lat, c0, r0, e;
        load_rand;
        c0 = cs_falls;
        r0 = rdy_cycles;
        request(lat);
        e = model_turb(2);
        step(3000 - (lat > 0 ? lat : 0));
        checks++;
        if (rdy_cycles - r0 !== 1) begin fails++; $display("FAIL held_ready_count got %0d exp 1", rdy_cycles - r0); end
        checks++;
        if (cs_falls - c0 !== 4) begin fails++; $display("FAIL held_frames got %0d exp 4", cs_falls - c0); end
        checks++;
        if (b0.turbidez !== 4'(e)) begin fails++; $display("FAIL held_turbidez got %0d exp %0d", b0.turbidez, e); end
        release_req;
        load_const(12'h200);
        request(lat);
        e = model_turb(2);
        checks++;
        if (lat !== LAT || b0.turbidez !== 4'(e)) begin
            fails++;
            $display("FAIL second_edge got lat=%0d turb=%0d exp lat=%0d turb=%0d", lat, b0.turbidez, LAT, e);
        end
        release_req;
    endtask

    task automatic test_abort;
        int lat, c0, s0, r0;
        load_const(12'hC00);
        request(lat);
        checks++;
        if (b0.turbidez !== 4'd12) begin fails++; $display("FAIL abort_prev got %0d exp 12", b0.turbidez); end
        release_req;
        load_rand;
        c0 = cs_falls;
        s0 = sclk_rises;
        r0 = rdy_cycles;
        b0.enable_esp = 1'b1;
        for (int n = 0; n < 1000 && sclk_rises - s0 < 24; n++) step(1);
        checks++;
        if (sclk_rises - s0 !== 24 || cs_falls - c0 !== 2) begin
            fails++;
            $display("FAIL abort_reach got rises=%0d frames=%0d exp rises=24 frames=2", sclk_rises - s0, cs_falls - c0);
        end
        b0.enable_esp = 1'b0;
        step(1);
        checks++;
        if (b0.adc_cs_n !== 1'b1 || b0.adc_sclk !== 1'b0) begin
            fails++;
            $display("FAIL abort_pins got cs_n=%b sclk=%b exp cs_n=1 sclk=0", b0.adc_cs_n, b0.adc_sclk);
        end
        step(700);
        checks++;
        if (rdy_cycles - r0 !== 0 || cs_falls - c0 !== 2) begin
            fails++;
            $display("FAIL abort_quiet got ready=%0d frames=%0d exp ready=0 frames=2", rdy_cycles - r0, cs_falls - c0);
        end
        checks++;
        if (b0.turbidez !== 4'd12) begin fails++; $display("FAIL abort_hold got %0d exp 12", b0.turbidez); end
    endtask

    task automatic test_reset_mid;
        int lat, c0, e;
        load_rand;
        c0 = cs_falls;
        b0.enable_esp = 1'b1;
        for (int n = 0; n < 1000 && cs_falls - c0 < 3; n++) step(1);
        checks++;
        if (cs_falls - c0 !== 3) begin fails++; $display("FAIL rmid_reach got %0d exp 3", cs_falls - c0); end
        step(20);
        reset = 1'b1;
        step(1);
        checks++;
        if ({b0.adc_cs_n, b0.adc_sclk, b0.turbidez, b0.ready_from_esp} !== 7'b1000000) begin
            fails++;
            $display("FAIL rmid_outputs got %b exp %b", {b0.adc_cs_n, b0.adc_sclk, b0.turbidez, b0.ready_from_esp}, 7'b1000000);
        end
        b0.enable_esp = 1'b0;
        step(2);
        reset = 1'b0;
        step(2);
        load_rand;
        request(lat);
        e = model_turb(2);
        checks++;
        if (lat !== LAT || b0.turbidez !== 4'(e)) begin
            fails++;
            $display("FAIL rmid_fresh got lat=%0d turb=%0d exp lat=%0d turb=%0d", lat, b0.turbidez, LAT, e);
        end
        release_req;
    endtask

    initial begin
        test_reset;
        test_single;
        test_average;
        test_random;
        test_held;
        test_abort;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
